prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Writer side of the instruction-fetch interface: fills a writable DEPTH-entry instruction store
//  from a valid/ready word stream, then serves combinational fetches at progCntr.
//  Sits beside the core in place of the constant instruction ROM. Gates the core via core_run.
// PARAMETERS
//  INSTR_W  12  instruction word width (opcode[0:2] | readLoc1[3:5] | readLoc2[6:8] | writeLoc[9:11])
//  DEPTH    8   number of instruction entries
//  ADDR_W   3   address width, log2(DEPTH); also the width of progCntr
// PORTS
//  clk          in   1           system clock, rising edge
//  rst          in   1           synchronous reset, active-high
//  load_start   in   1           request a new program load; sampled in IDLE and RUN
//  load_len     in   ADDR_W+1    word count for this load, captured with load_start; legal 1..DEPTH
//  in_valid     in   1           stream word valid
//  in_data      in   [0:INSTR_W-1] stream word
//  in_ready     out  1           loader accepts in_data this cycle
//  progCntr     in   [0:ADDR_W-1] fetch address from the PC
//  instruction  out  [0:INSTR_W-1] fetched word
//  core_run     out  1           core may advance PC and write registers
//  load_done    out  1           one-cycle pulse: load completed successfully
//  err          out  1           sticky error flag; cleared by the next accepted load_start
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, all entries=0, wr_ptr=0, in_ready=0, core_run=0,
//    load_done=0, err=0. rst overrides every other input, including in mid-load.
//  - FSM IDLE -> LOAD -> [CHECK] -> RUN. All outputs except instruction are registered.
//  - IDLE: if load_start and 1<=load_len<=DEPTH, capture len, zero all entries, wr_ptr=0,
//    err=0, go to LOAD. If load_start with an illegal len (0 or >DEPTH), set err=1 and stay in IDLE.
//  - LOAD: in_ready=1. A transfer occurs on in_valid&in_ready; it writes mem[wr_ptr] and then
//    increments wr_ptr. in_valid without in_ready transfers nothing. On the transfer of word len-1
//    the next state is RUN, or CHECK when LOADER_CHECKSUM_EN is defined.
//    load_start is ignored in LOAD.
//  - RUN: core_run=1, in_ready=0. load_start with a legal len drops core_run at the same edge
//    that enters LOAD; entries are re-zeroed. An illegal len sets err=1 and leaves the FSM in RUN.
//  - load_done pulses high for exactly one cycle: the first cycle in RUN after a LOAD or CHECK.
//  - Fetch: instruction = mem[progCntr] combinationally while state==RUN; 0 in every other state.
//    A write and a fetch to the same address in the same cycle cannot occur, because the two
//    are in disjoint states.
//  - wr_ptr never wraps: len<=DEPTH bounds it. Entries at or beyond len read as 0.
//  - Latency: the last data word is accepted at edge N; core_run=1 and load_done=1 after edge N+1.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//    - After the last data word, the loader enters CHECK with in_ready=1 and accepts one more word:
//      the XOR of all len data words.
//    - Match: go to RUN with a load_done pulse.
//    - Mismatch: set err=1, go to IDLE, no load_done pulse. Entries keep the loaded words,
//      but instruction reads 0 outside RUN.
//  LOADER_CHECKSUM_EN not defined:
//    - CHECK state is absent; LOAD goes directly to RUN; err is raised only by an illegal len.
// TESTING
//  T1 reset: rst=1 for 2 cycles -> core_run=0, in_ready=0, err=0, instruction=0 for any progCntr.
//  T2 basic load: load_start, len=5, stream 576,1152,1728,2304,505 with in_valid gaps
//     -> load_done pulses once; in RUN, progCntr=0..7 reads 576,1152,1728,2304,505,0,0,0.
//  T3 bad length: load_start with len=0, then with len=9 -> err=1 each time, state unchanged,
//     in_ready stays 0; then a legal load clears err.
//  T4 reload in RUN: after T2, load_start len=2 with words 7,9 -> core_run=0 at the next edge;
//     then RUN with progCntr=0..2 reading 7,9,0.
//  T5 reset mid-load: rst after 3 of 5 words -> IDLE, all entries 0, no load_done pulse.
//  T6 (LOADER_CHECKSUM_EN): T2 words, then checksum 2297 -> RUN and load_done;
//     the same words with checksum 2296 -> err=1, IDLE, core_run=0.

Source files
------------

// File: rtl/prog_loader.sv
// Writable instruction store filled from a valid/ready stream, then fetched at progCntr while running.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum word validated before the core runs.
module prog_loader #(
  parameter int INSTR_W = 12,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic [ADDR_W:0]     load_len,
  input  logic                in_valid,
  input  logic [0:INSTR_W-1]  in_data,
  output logic                in_ready,
  input  logic [0:ADDR_W-1]   progCntr,
  output logic [0:INSTR_W-1]  instruction,
  output logic                core_run,
  output logic                load_done,
  output logic                err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, RUN} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
`endif

  state_t             state_q, state_d;
  logic [ADDR_W:0]    len_q;
  logic [ADDR_W:0]    wr_ptr;
  logic [INSTR_W-1:0] mem [0:DEPTH-1];
  logic               fresh_q;

  logic [INSTR_W-1:0] din;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               len_ok;
  logic               can_start;
  logic               start_ok;
  logic               start_bad;
  logic               xfer;
  logic               last_word;
  logic               csum_bad;

`ifdef LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0] csum_q;
`endif

  assign din        = in_data;
  assign fetch_addr = progCntr;
  assign len_ok     = (load_len != '0) && ({1'b0, load_len} <= (ADDR_W+2)'(DEPTH));
  assign can_start  = (state_q == IDLE) || (state_q == RUN);
  assign start_ok   = load_start && len_ok && can_start;
  assign start_bad  = load_start && !len_ok && can_start;
  assign xfer       = in_valid && in_ready;
  assign last_word  = (wr_ptr == len_q - 1'b1);

  always_comb begin
    state_d  = state_q;
    csum_bad = 1'b0;
    case (state_q)
      IDLE: if (start_ok) state_d = LOAD;
      LOAD: begin
        if (xfer && last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = RUN;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          csum_bad = (din != csum_q);
          state_d  = csum_bad ? IDLE : RUN;
        end
      end
`endif
      RUN:  if (start_ok) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // core_run and load_done rise one edge after RUN is entered; fresh_q marks that first RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      wr_ptr    <= '0;
      fresh_q   <= 1'b0;
      in_ready  <= 1'b0;
      core_run  <= 1'b0;
      load_done <= 1'b0;
      err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state_q   <= state_d;
`ifdef LOADER_CHECKSUM_EN
      in_ready  <= (state_d == LOAD) || (state_d == CHECK);
`else
      in_ready  <= (state_d == LOAD);
`endif
      core_run  <= (state_q == RUN) && (state_d == RUN);
      load_done <= fresh_q && (state_d == RUN);
      fresh_q   <= (state_q != RUN) && (state_d == RUN);

      if (start_ok) begin
        err    <= 1'b0;
        len_q  <= load_len;
        wr_ptr <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_q <= '0;
`endif
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (start_bad || csum_bad) begin
        err <= 1'b1;
      end

      if (state_q == LOAD && xfer) begin
        mem[wr_ptr[ADDR_W-1:0]] <= din;
        wr_ptr                  <= wr_ptr + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        csum_q                  <= csum_q ^ din;
`endif
      end
    end
  end

  assign instruction = (state_q == RUN) ? mem[fetch_addr] : '0;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a simple program-image model.
// Define LOADER_CHECKSUM_EN for both files to exercise the checksum path.
module tb_prog_loader;
  localparam int INSTR_W = 12;
  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                load_start;
  logic [ADDR_W:0]     load_len;
  logic                in_valid;
  logic [0:INSTR_W-1]  in_data;
  logic                in_ready;
  logic [0:ADDR_W-1]   progCntr;
  logic [0:INSTR_W-1]  instruction;
  logic                core_run;
  logic                load_done;
  logic                err;

  prog_loader #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .progCntr(progCntr), .instruction(instruction),
    .core_run(core_run), .load_done(load_done), .err(err)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  // Model of the program image and loader status as the core would see it
  logic [INSTR_W-1:0] model_mem [DEPTH];
  bit                 model_err;
  bit                 model_run;
  logic [INSTR_W-1:0] words [$];

  always @(posedge clk) begin
    #1;
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkFetch(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      progCntr = a[ADDR_W-1:0];
      #1;
      checkOutput($sformatf("%s_pc%0d", tag, a), instruction, model_run ? model_mem[a] : 0);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; load_start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_run = 0; model_err = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    checkOutput("rst_core_run", core_run, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_load_done", load_done, 0);
    rst = 1'b0;
  endtask

  task automatic startLoad(input int len);
    bit legal;
    legal = (len >= 1) && (len <= DEPTH);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = len[ADDR_W:0];
    @(negedge clk);
    load_start = 1'b0;
    if (legal) begin
      model_err = 0;
      model_run = 0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else begin
      model_err = 1;
    end
    checkOutput("start_err", err, model_err);
    checkOutput("start_in_ready", in_ready, legal);
    checkOutput("start_core_run", core_run, model_run);
  endtask

  // Streams the queued words with random valid gaps; nsend < 0 sends everything
  task automatic applyStimulus(input int len, input int nsend, input bit bad_csum);
    int idx = 0;
    int cyc = 0;
    int ntot = len;
    logic [INSTR_W-1:0] cs = '0;
    for (int i = 0; i < len; i++) cs ^= words[i];
`ifdef LOADER_CHECKSUM_EN
    ntot = len + 1;
`endif
    if (nsend >= 0) ntot = nsend;
    while (idx < ntot && cyc < 300) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = (idx < len) ? words[idx] : (cs ^ {{(INSTR_W-1){1'b0}}, bad_csum});
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("stream_bounded", (cyc < 300), 1);
    for (int i = 0; i < len && i < ntot; i++) model_mem[i] = words[i];
  endtask

  task automatic finishLoad(input bit ok);
    int d0;
    d0 = done_cnt;
    checkOutput("end_in_ready", in_ready, 0);
    if (ok) checkOutput("end_core_run_wait", core_run, 0);
    @(negedge clk);
    if (ok) begin
      model_run = 1;
      checkOutput("end_core_run", core_run, 1);
      checkOutput("end_load_done", load_done, 1);
    end else begin
      model_err = 1;
      model_run = 0;
      checkOutput("end_core_run_bad", core_run, 0);
      checkOutput("end_load_done_bad", load_done, 0);
    end
    checkOutput("end_err", err, model_err);
    @(negedge clk);
    checkOutput("end_load_done_low", load_done, 0);
    checkOutput("end_done_count", done_cnt - d0, ok ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len;
    int d0;
    rst = 1'b0; load_start = 1'b0; load_len = '0;
    in_valid = 1'b0; in_data = '0; progCntr = '0;

    doReset();
    checkFetch("reset");

    words = '{12'd576, 12'd1152, 12'd1728, 12'd2304, 12'd505};
    startLoad(5);
    applyStimulus(5, -1, 1'b0);
    finishLoad(1);
    checkFetch("basic");

    startLoad(0);
    checkFetch("bad_len_run");

    words = '{12'd7, 12'd9};
    startLoad(2);
    applyStimulus(2, -1, 1'b0);
    finishLoad(1);
    checkFetch("reload");

    doReset();
    startLoad(0);
    startLoad(9);
    words = '{12'd100, 12'd200, 12'd300};
    startLoad(3);
    applyStimulus(3, -1, 1'b0);
    finishLoad(1);
    checkFetch("after_bad_len");

    doReset();
    words = '{12'd11, 12'd22, 12'd33, 12'd44, 12'd55};
    startLoad(5);
    applyStimulus(5, 3, 1'b0);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_run = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_core_run", core_run, 0);
    checkOutput("midrst_err", err, 0);
    repeat (4) @(negedge clk);
    checkOutput("midrst_no_done", done_cnt - d0, 0);
    checkFetch("midrst_idle");
    words = '{12'd4095};
    startLoad(1);
    applyStimulus(1, -1, 1'b0);
    finishLoad(1);
    checkFetch("midrst_reload");

    repeat (6) begin
      len = $urandom_range(1, DEPTH);
      words = {};
      for (int i = 0; i < len; i++) words.push_back(INSTR_W'($urandom));
      startLoad(len);
      applyStimulus(len, -1, 1'b0);
      finishLoad(1);
      checkFetch($sformatf("rand_len%0d", len));
    end

`ifdef LOADER_CHECKSUM_EN
    words = '{12'd576, 12'd1152, 12'd1728, 12'd2304, 12'd505};
    startLoad(5);
    applyStimulus(5, -1, 1'b0);
    finishLoad(1);
    checkFetch("csum_good");
    startLoad(5);
    applyStimulus(5, -1, 1'b1);
    finishLoad(0);
    checkFetch("csum_bad");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
